dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter and sequencer for the single-port word-addressed data memory. Port 0 (CPU load/store) and port 1 (debug/loader) each issue one-word read or write requests over valid/ready handshakes. The block serialises them with round-robin priority and drives the memory's address/write-enable/write-data inputs from registers. It captures the memory's combinational read data and returns it to the winning requester. It sits between the pipeline's memory stage plus the debug loader and the data memory instance.

## Interface
- ADDR_W, 32, requester and memory address width (word index)
- DATA_W, 32, data width
- MEM_DEPTH, 128, number of valid words; addresses >= MEM_DEPTH are out of range
- CLK  in  1  sole clock, rising edge
- RESET  in  1  synchronous, active-high reset
- m0_req_valid / m1_req_valid  in  1  request present
- m0_req_ready / m1_req_ready  out  1  request accepted this cycle
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  ADDR_W  word address
- m0_wdata / m1_wdata  in  DATA_W  write data
- m0_rsp_valid / m1_rsp_valid  out  1  response present
- m0_rsp_ready / m1_rsp_ready  in  1  requester takes response
- m0_rdata / m1_rdata  out  DATA_W  read data (0 for writes and errors)
- m0_err / m1_err  out  1  address out of range, valid with rsp_valid
- mem_addr  out  ADDR_W  to memory Address
- mem_we  out  1  to memory WE
- mem_wd  out  DATA_W  to memory WD
- mem_rd  in  DATA_W  from memory ReadData (combinational)
- busy  out  1  state != IDLE

## Operation
- FSM states IDLE, ISSUE, RESP.
- IDLE:
  - Grant is combinational. If only one req_valid is high, that port wins. If both are high, the port not granted last wins (rr pointer `last`).
  - mX_req_ready = (state==IDLE) && granted X. At most one ready is high per cycle.
  - On handshake, latch port id, we, addr, wdata, and err = (addr >= MEM_DEPTH). Update `last` to the winner. Go to ISSUE.
- ISSUE (exactly one cycle):
  - mem_addr/mem_wd are driven from latched regs.
  - mem_we = latched we && !err && !RESET. The write commits at the closing edge.
  - For a read, capture rdata = err ? 0 : mem_rd. For a write, rdata = 0. Go to RESP.
- RESP:
  - rsp_valid is high only for the latched port; rdata/err are held stable.
  - On rsp_valid && rsp_ready, go to IDLE.
  - New requests are not accepted in RESP.
- Out-of-range requests: never write memory, return err=1, rdata=0. Memory content is unchanged.
- Requesters hold valid and payload stable until ready. The block does not check this.
- Outside ISSUE: mem_we=0; mem_addr/mem_wd hold the last latched values.

## Timing
- Reset values: state=IDLE, last=1 (port 0 wins the first tie), all req_ready/rsp_valid=0, rdata=0, err=0, mem_we=0, mem_addr=0, mem_wd=0, busy=0.
- Latency: handshake at edge k, ISSUE during cycle k+1, rsp_valid from cycle k+2. The minimum back-to-back period is 3 cycles per access (rsp_ready tied high).
- Throughput: one outstanding access in total.
- Simultaneous requests: the loser's valid stays high. It wins the next IDLE cycle unless it is not requesting.
- RESET high during ISSUE: mem_we is gated low, so there is no write. The next state is IDLE.
- RESET during RESP: the response is dropped and rsp_valid=0 on the next cycle.
- rsp_ready high in the first RESP cycle: IDLE follows the next cycle. A new grant is possible in that IDLE cycle.

## Structure
- Shared package dmem_pkg:
  - state enum {IDLE, ISSUE, RESP}
  - port-id type (1 bit)
  - default widths and MEM_DEPTH constant
- One natural sub-module, rr_arb2: 2-way round-robin grant from the two valids and `last`. It produces grant onehot and id.
- FSM, request latch and response registers live in dmem_arbiter.

## Test plan
- Port 0 writes 0xDEADBEEF to addr 5, then reads addr 5. Required:
  - mem_we high for exactly one cycle, in the ISSUE cycle.
  - Read response: m0_rdata=0xDEADBEEF, err=0, arriving 2 cycles after the handshake.
- Both ports request reads in the same cycle after reset. Required: port 0 is served first, port 1 second. With both continuously requesting, grants alternate 0,1,0,1.
- Port 1 writes to addr 128. Required: m1_err=1, rdata=0, mem_we never asserts, and word 0 is unchanged.
- m0_rsp_ready is held low for 4 cycles. Required: rsp_valid and rdata stay stable, m1_req_ready stays 0, and busy=1 throughout.
- RESET is asserted during the ISSUE cycle of a write of 0x12345678 to addr 3. Required: mem_we=0, addr 3 keeps its old value, and all outputs hold reset values the next cycle.
- Preloaded words: reads of addr 1 and addr 2 return 0x00000002 and 0xFFFFFFFE.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and default sizes for the data-memory arbiter.
package dmem_pkg;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MEM_DEPTH = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef logic port_id_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester handshakes plus memory-side bus between the two requesters, the arbiter and the memory.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req_valid, m0_req_ready, m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_rsp_valid, m0_rsp_ready, m0_err;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req_valid, m1_req_ready, m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_rsp_valid, m1_rsp_ready, m1_err;
  logic [DATA_W-1:0] m1_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_rd;

  modport slave (
    input  m0_req_valid, m0_we, m0_addr, m0_wdata, m0_rsp_ready,
    output m0_req_ready, m0_rsp_valid, m0_rdata, m0_err,
    input  m1_req_valid, m1_we, m1_addr, m1_wdata, m1_rsp_ready,
    output m1_req_ready, m1_rsp_valid, m1_rdata, m1_err,
    output mem_addr, mem_we, mem_wd,
    input  mem_rd
  );

  modport master (
    output m0_req_valid, m0_we, m0_addr, m0_wdata, m0_rsp_ready,
    input  m0_req_ready, m0_rsp_valid, m0_rdata, m0_err,
    output m1_req_valid, m1_we, m1_addr, m1_wdata, m1_rsp_ready,
    input  m1_req_ready, m1_rsp_valid, m1_rdata, m1_err,
    input  mem_addr, mem_we, mem_wd,
    output mem_rd
  );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant: a tie goes to the port that did not win last.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic [1:0] valid_i,
  input  port_id_t   last_i,
  output logic [1:0] gnt_o,
  output port_id_t   id_o
);
  always_comb begin
    id_o  = 1'b0;
    gnt_o = 2'b00;
    case (valid_i)
      2'b01:   id_o = 1'b0;
      2'b10:   id_o = 1'b1;
      2'b11:   id_o = ~last_i;
      default: id_o = 1'b0;
    endcase
    if (|valid_i) gnt_o = id_o ? 2'b10 : 2'b01;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Serialises two one-word requesters onto the single-port data memory:
// IDLE grants, ISSUE drives the memory for one cycle, RESP holds the result.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW    = ADDR_W,
  parameter int DW    = DATA_W,
  parameter int DEPTH = MEM_DEPTH
) (
  input  logic           clk_i,
  input  logic           rst_i,
  dmem_arbiter_if.slave  bus,
  output logic           busy_o
);
  state_e          state_q, state_d;
  port_id_t        last_q, last_d;
  port_id_t        id_q, id_d;
  logic            we_q, we_d;
  logic            err_q, err_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  logic [1:0]      vld, gnt;
  port_id_t        gnt_id;
  logic            in_idle, hs, rsp_v, rsp_rdy;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

  assign vld = {bus.m1_req_valid, bus.m0_req_valid};

  rr_arb2 u_arb (
    .valid_i (vld),
    .last_i  (last_q),
    .gnt_o   (gnt),
    .id_o    (gnt_id)
  );

  assign in_idle          = (state_q == IDLE);
  assign hs               = in_idle & (|vld);
  assign bus.m0_req_ready = in_idle & gnt[0];
  assign bus.m1_req_ready = in_idle & gnt[1];

  assign sel_we    = gnt_id ? bus.m1_we    : bus.m0_we;
  assign sel_addr  = gnt_id ? bus.m1_addr  : bus.m0_addr;
  assign sel_wdata = gnt_id ? bus.m1_wdata : bus.m0_wdata;
  assign rsp_rdy   = id_q   ? bus.m1_rsp_ready : bus.m0_rsp_ready;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    we_d    = we_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (hs) begin
        state_d = ISSUE;
        id_d    = gnt_id;
        last_d  = gnt_id;
        we_d    = sel_we;
        addr_d  = sel_addr;
        wdata_d = sel_wdata;
        err_d   = (sel_addr >= AW'(DEPTH));
      end
      ISSUE: begin
        // Memory read data is combinational; sample it while the address is driven.
        rdata_d = (we_q || err_q) ? '0 : bus.mem_rd;
        state_d = RESP;
      end
      RESP: if (rsp_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign rsp_v            = (state_q == RESP);
  assign bus.m0_rsp_valid = rsp_v & ~id_q;
  assign bus.m1_rsp_valid = rsp_v &  id_q;
  assign bus.m0_rdata     = bus.m0_rsp_valid ? rdata_q : '0;
  assign bus.m1_rdata     = bus.m1_rsp_valid ? rdata_q : '0;
  assign bus.m0_err       = bus.m0_rsp_valid & err_q;
  assign bus.m1_err       = bus.m1_rsp_valid & err_q;

  // Reset gates the strobe directly so a write aborted mid-ISSUE never lands.
  assign bus.mem_we   = (state_q == ISSUE) & we_q & ~err_q & ~rst_i;
  assign bus.mem_addr = addr_q;
  assign bus.mem_wd   = wdata_q;
  assign busy_o       = ~in_idle;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural 128-word memory and a response scoreboard.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tb_init = 1'b0;
  logic busy;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_arbiter u_dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus    (bus),
    .busy_o (busy)
  );

  logic [31:0] mem [0:127];
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'h0;
      mem[1] <= 32'h0000_0002;
      mem[2] <= 32'hFFFF_FFFE;
    end else if (bus.mem_we && bus.mem_addr < 128) begin
      mem[bus.mem_addr[6:0]] <= bus.mem_wd;
    end
  end
  assign bus.mem_rd = (bus.mem_addr < 128) ? mem[bus.mem_addr[6:0]] : 32'h0;

  int          we_cnt = 0;
  time         we_t = 0;
  logic [31:0] we_a = 0, we_d = 0;
  always @(negedge clk) if (bus.mem_we) begin
    we_cnt = we_cnt + 1;
    we_t   = $time;
    we_a   = bus.mem_addr;
    we_d   = bus.mem_wd;
  end

  typedef struct { int p; logic [31:0] d; logic e; } exp_t;
  exp_t sbq[$];
  int   checks = 0, errors = 0;
  time  hs_t = 0;

  function automatic logic rdy(int p);   return p ? bus.m1_req_ready : bus.m0_req_ready; endfunction
  function automatic logic rspv(int p);  return p ? bus.m1_rsp_valid : bus.m0_rsp_valid; endfunction
  function automatic logic [31:0] rdat(int p); return p ? bus.m1_rdata : bus.m0_rdata; endfunction
  function automatic logic rerr(int p);  return p ? bus.m1_err : bus.m0_err; endfunction

  task automatic set_req(input int p, input logic v, input logic we, input logic [31:0] a, input logic [31:0] wd);
    if (p == 0) begin
      bus.m0_req_valid = v; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = wd;
    end else begin
      bus.m1_req_valid = v; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = wd;
    end
  endtask

  task automatic pop_exp(output exp_t e);
    if (sbq.size() > 0) e = sbq.pop_front();
    else e = '{-1, 32'hxxxx_xxxx, 1'bx};
  endtask

  task automatic apply_reset(input logic init);
    @(posedge clk); #1;
    rst = 1'b1; tb_init = init;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; tb_init = 1'b0;
  endtask

  // Returns after the handshake edge (+1); to=1 if ready never came.
  task automatic issue(input int p, input logic we, input logic [31:0] a, input logic [31:0] wd, output bit to);
    set_req(p, 1'b1, we, a, wd);
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rdy(p)) begin to = 1'b0; break; end
    end
    @(posedge clk); hs_t = $time;
    #1 set_req(p, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // lat counts falling edges after the handshake until rsp_valid; -1 on timeout.
  task automatic get_rsp(input int p, output logic [31:0] rd, output logic er, output int lat);
    lat = -1; rd = 32'hx; er = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rspv(p)) begin rd = rdat(p); er = rerr(p); lat = i; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1; tb_init = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.m0_req_ready !== 1'b0 || bus.m1_req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b%b want 00", bus.m1_req_ready, bus.m0_req_ready); end
    checks++; if (bus.m0_rsp_valid !== 1'b0 || bus.m1_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b%b want 00", bus.m1_rsp_valid, bus.m0_rsp_valid); end
    checks++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h0 || bus.mem_wd !== 32'h0) begin errors++; $display("FAIL rst_mem got we=%b a=%h wd=%h want 0/0/0", bus.mem_we, bus.mem_addr, bus.mem_wd); end
    checks++; if (busy !== 1'b0 || bus.m0_rdata !== 32'h0 || bus.m0_err !== 1'b0) begin errors++; $display("FAIL rst_out got busy=%b rd=%h err=%b want 0", busy, bus.m0_rdata, bus.m0_err); end
    @(posedge clk); #1 rst = 1'b0; tb_init = 1'b0;
  endtask

  task automatic test_write_read();
    int w0, lat; bit to; logic [31:0] rd; logic er; exp_t e;
    w0 = we_cnt;
    sbq.push_back('{0, 32'h0, 1'b0});
    issue(0, 1'b1, 32'd5, 32'hDEAD_BEEF, to);
    get_rsp(0, rd, er, lat);
    pop_exp(e);
    checks++; if (to || lat != 2) begin errors++; $display("FAIL wr_latency got to=%0d lat=%0d want 0/2", to, lat); end
    checks++; if (rd !== e.d || er !== e.e) begin errors++; $display("FAIL wr_rsp got %h/%b want %h/%b", rd, er, e.d, e.e); end
    checks++; if (we_cnt - w0 != 1) begin errors++; $display("FAIL wr_we_count got %0d want 1", we_cnt - w0); end
    checks++; if (we_t != hs_t + 5 || we_a !== 32'd5 || we_d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_we_cycle got t=%0t a=%h d=%h want t=%0t a=5 d=deadbeef", we_t, we_a, we_d, hs_t + 5); end
    w0 = we_cnt;
    sbq.push_back('{0, 32'hDEAD_BEEF, 1'b0});
    issue(0, 1'b0, 32'd5, 32'h0, to);
    get_rsp(0, rd, er, lat);
    pop_exp(e);
    checks++; if (to || lat != 2) begin errors++; $display("FAIL rd_latency got to=%0d lat=%0d want 0/2", to, lat); end
    checks++; if (rd !== e.d || er !== e.e) begin errors++; $display("FAIL rd_rsp got %h/%b want %h/%b", rd, er, e.d, e.e); end
    checks++; if (we_cnt != w0) begin errors++; $display("FAIL rd_no_we got %0d want 0", we_cnt - w0); end
  endtask

  task automatic test_tie();
    int g[$]; int nrsp, both, p; exp_t e;
    nrsp = 0; both = 0;
    apply_reset(1'b0);
    set_req(0, 1'b1, 1'b0, 32'd1, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'd2, 32'h0);
    for (int c = 0; c < 60 && nrsp < 4; c++) begin
      @(negedge clk);
      if (bus.m0_req_ready && bus.m1_req_ready) both++;
      if (bus.m0_req_ready) begin g.push_back(0); sbq.push_back('{0, 32'h0000_0002, 1'b0}); end
      else if (bus.m1_req_ready) begin g.push_back(1); sbq.push_back('{1, 32'hFFFF_FFFE, 1'b0}); end
      if (bus.m0_rsp_valid || bus.m1_rsp_valid) begin
        p = bus.m1_rsp_valid ? 1 : 0;
        pop_exp(e);
        checks++; if (p != e.p || rdat(p) !== e.d || rerr(p) !== e.e) begin errors++; $display("FAIL tie_rsp%0d got p=%0d %h/%b want p=%0d %h/%b", nrsp, p, rdat(p), rerr(p), e.p, e.d, e.e); end
        nrsp++;
      end
      if (g.size() == 4 && bus.m0_req_valid) begin
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
      end
    end
    checks++; if (nrsp != 4 || g.size() != 4) begin errors++; $display("FAIL tie_count got rsp=%0d gnt=%0d want 4/4", nrsp, g.size()); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (k >= g.size() || g[k] != (k % 2)) begin errors++; $display("FAIL tie_order%0d got %0d want %0d", k, (k < g.size()) ? g[k] : -1, k % 2); end
    end
    checks++; if (both != 0) begin errors++; $display("FAIL tie_onehot got %0d dual-ready cycles want 0", both); end
  endtask

  task automatic test_oor();
    int w0, lat; bit to; logic [31:0] rd; logic er; exp_t e;
    w0 = we_cnt;
    sbq.push_back('{1, 32'h0, 1'b1});
    issue(1, 1'b1, 32'd128, 32'hA5A5_A5A5, to);
    get_rsp(1, rd, er, lat);
    pop_exp(e);
    checks++; if (to || lat != 2 || rd !== e.d || er !== e.e) begin errors++; $display("FAIL oor_rsp got lat=%0d %h/%b want 2 %h/%b", lat, rd, er, e.d, e.e); end
    checks++; if (we_cnt != w0) begin errors++; $display("FAIL oor_we got %0d strobes want 0", we_cnt - w0); end
    sbq.push_back('{0, 32'h0, 1'b0});
    issue(0, 1'b0, 32'd0, 32'h0, to);
    get_rsp(0, rd, er, lat);
    pop_exp(e);
    checks++; if (to || rd !== e.d || er !== e.e) begin errors++; $display("FAIL oor_word0 got %h/%b want %h/%b", rd, er, e.d, e.e); end
  endtask

  task automatic test_backpressure();
    int lat; bit to, seen; logic [31:0] rd; logic er; exp_t e;
    bus.m0_rsp_ready = 1'b0;
    sbq.push_back('{0, 32'hDEAD_BEEF, 1'b0});
    issue(0, 1'b0, 32'd5, 32'h0, to);
    set_req(1, 1'b1, 1'b0, 32'd1, 32'h0);
    pop_exp(e);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.m0_rsp_valid) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL bp_rsp_timeout got none want rsp_valid"); end
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      checks++;
      if (bus.m0_rsp_valid !== 1'b1 || bus.m0_rdata !== e.d || bus.m0_err !== e.e || bus.m1_req_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d got v=%b rd=%h err=%b r1=%b busy=%b want 1 %h %b 0 1", c, bus.m0_rsp_valid, bus.m0_rdata, bus.m0_err, bus.m1_req_ready, busy, e.d, e.e);
      end
    end
    bus.m0_rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.m1_req_ready !== 1'b1 || bus.m0_rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release got r1=%b v0=%b want 1/0", bus.m1_req_ready, bus.m0_rsp_valid); end
    sbq.push_back('{1, 32'h0000_0002, 1'b0});
    @(posedge clk); #1 set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    get_rsp(1, rd, er, lat);
    pop_exp(e);
    checks++; if (lat != 2 || rd !== e.d || er !== e.e) begin errors++; $display("FAIL bp_next got lat=%0d %h/%b want 2 %h/%b", lat, rd, er, e.d, e.e); end
  endtask

  task automatic test_reset_issue();
    int w0, lat; bit to; logic [31:0] rd; logic er; exp_t e;
    w0 = we_cnt;
    issue(0, 1'b1, 32'd3, 32'h1234_5678, to);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (to || bus.mem_we !== 1'b0) begin errors++; $display("FAIL ri_we got to=%0d we=%b want 0/0", to, bus.mem_we); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus.m0_rsp_valid !== 1'b0 || bus.m1_rsp_valid !== 1'b0 || bus.mem_we !== 1'b0 ||
        bus.mem_addr !== 32'h0 || bus.mem_wd !== 32'h0 || bus.m0_rdata !== 32'h0 || bus.m0_err !== 1'b0 ||
        bus.m0_req_ready !== 1'b0 || bus.m1_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL ri_outputs got busy=%b v=%b%b we=%b a=%h wd=%h rd=%h want all 0", busy, bus.m1_rsp_valid, bus.m0_rsp_valid, bus.mem_we, bus.mem_addr, bus.mem_wd, bus.m0_rdata);
    end
    checks++; if (we_cnt != w0) begin errors++; $display("FAIL ri_we_count got %0d want 0", we_cnt - w0); end
    sbq.push_back('{0, 32'h0, 1'b0});
    issue(0, 1'b0, 32'd3, 32'h0, to);
    get_rsp(0, rd, er, lat);
    pop_exp(e);
    checks++; if (to || rd !== e.d || er !== e.e) begin errors++; $display("FAIL ri_addr3 got %h/%b want %h/%b", rd, er, e.d, e.e); end
  endtask

  initial begin
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    bus.m0_rsp_ready = 1'b1;
    bus.m1_rsp_ready = 1'b1;
    test_reset();
    test_write_read();
    test_tie();
    test_oor();
    test_backpressure();
    test_reset_issue();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
